mem_access_seq: RTL and testbench

MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

---
 rtl/mem_access_seq.sv | 153 +++++++++++++++
 tb/tb_mem_access_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_seq.sv
// -----------------------------------------------------------------------------
// mem_access_seq
//
// Purpose:
//   Instruction-cycle timing sequencer for a simple accumulator-style CPU.
//   It steps through timing states T0..T5 and latches the opcode decode (D)
//   and the indirect bit (I) at T2. It drives the memory READ/WRITE strobes
//   and ends each instruction on its opcode-dependent final step. It can halt
//   at an instruction boundary, and it can optionally stall on memory.
//
// Build option:
//   MEM_ACCESS_SEQ_WAIT_EN - when defined, an access with mem_ready=0 stalls
//                            the sequencer in WAIT. When undefined,
//                            mem_ready is ignored and every step takes one
//                            cycle.
//
// Ports:
//   clk        in   1  clock, all state on the rising edge
//   rst        in   1  asynchronous active-high reset
//   start      in   1  begin instruction cycles from IDLE or HALTED
//   halt_req   in   1  stop at the next instruction boundary
//   ir_op      in   3  opcode field IR[14:12]
//   ir_i       in   1  indirect bit IR[15]
//   mem_ready  in   1  memory completes the current access this cycle
//   T          out  6  one-hot timing step, zero when not running
//   D          out  8  one-hot latched opcode decode
//   READ       out  1  memory read strobe
//   WRITE      out  1  memory write strobe
//   busy       out  1  high in RUN or WAIT
//   instr_done out  1  pulse on the final step of each instruction
// -----------------------------------------------------------------------------
module mem_access_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       halt_req,
    input  logic [2:0] ir_op,
    input  logic       ir_i,
    input  logic       mem_ready,
    output logic [5:0] T,
    output logic [7:0] D,
    output logic       READ,
    output logic       WRITE,
    output logic       busy,
    output logic       instr_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        WAIT   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t     state;
    logic [5:0] t_reg;      // one-hot step, all-zero outside RUN/WAIT
    logic [7:0] d_reg;
    logic       i_reg;
    logic       halt_pend;  // halt_req seen since the last boundary

    logic       running;
    logic       last_step;
    logic       stall;

    assign running = (state == RUN) || (state == WAIT);

    // Final step depends on the decoded opcode; D is already valid from T3.
    assign last_step = running &&
                       ((t_reg[3] && d_reg[7]) ||
                        (t_reg[4] && (d_reg[3] || d_reg[4])) ||
                        (t_reg[5] && (d_reg[0] || d_reg[1] || d_reg[2] ||
                                      d_reg[5] || d_reg[6])));

    always_comb begin
        READ  = 1'b0;
        WRITE = 1'b0;
        if (running) begin
            READ  = t_reg[1] ||
                    (!d_reg[7] && i_reg && t_reg[3]) ||
                    ((d_reg[0] || d_reg[1] || d_reg[2] || d_reg[6]) && t_reg[4]);
            WRITE = ((d_reg[3] || d_reg[5]) && t_reg[4]) ||
                    (d_reg[6] && t_reg[5]);
        end
    end

`ifdef MEM_ACCESS_SEQ_WAIT_EN
    // T0 and T2 never strobe memory, so they can never stall.
    assign stall = (READ || WRITE) && !mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign stall = 1'b0;
`endif

    assign T          = t_reg;
    assign D          = d_reg;
    assign busy       = running;
    assign instr_done = last_step && !stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            t_reg     <= 6'b000000;
            d_reg     <= 8'h00;
            i_reg     <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state     <= RUN;
                        t_reg     <= 6'b000001;
                        // A simultaneous halt request takes effect at the
                        // first boundary.
                        halt_pend <= halt_req;
                    end else begin
                        halt_pend <= 1'b0;
                    end
                end
                RUN, WAIT: begin
                    if (stall) begin
                        state     <= WAIT;
                        halt_pend <= halt_pend || halt_req;
                    end else begin
                        if (t_reg[2]) begin
                            d_reg <= 8'd1 << ir_op;
                            i_reg <= ir_i;
                        end
                        if (last_step) begin
                            halt_pend <= 1'b0;
                            if (halt_pend || halt_req) begin
                                state <= HALTED;
                                t_reg <= 6'b000000;
                            end else begin
                                state <= RUN;
                                t_reg <= 6'b000001;
                            end
                        end else begin
                            state     <= RUN;
                            t_reg     <= {t_reg[4:0], 1'b0};
                            halt_pend <= halt_pend || halt_req;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    t_reg <= 6'b000000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// -----------------------------------------------------------------------------
// tb_mem_access_seq
//
// Purpose:
//   Directed self-checking bench for mem_access_seq. It runs a linear
//   sequence of instruction scenarios and checks T, READ, WRITE and
//   instr_done every cycle against hand-computed values. It also checks D,
//   busy, halting and reset behaviour. The expectations for the stalled
//   scenario follow the MEM_ACCESS_SEQ_WAIT_EN build option.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_mem_access_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       halt_req;
    logic [2:0] ir_op;
    logic       ir_i;
    logic       mem_ready;
    logic [5:0] T;
    logic [7:0] D;
    logic       READ;
    logic       WRITE;
    logic       busy;
    logic       instr_done;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] T0 = 6'b000001, T1 = 6'b000010, T2 = 6'b000100,
                           T3 = 6'b001000, T4 = 6'b010000, T5 = 6'b100000,
                           TZ = 6'b000000;

    mem_access_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .halt_req   (halt_req),
        .ir_op      (ir_op),
        .ir_i       (ir_i),
        .mem_ready  (mem_ready),
        .T          (T),
        .D          (D),
        .READ       (READ),
        .WRITE      (WRITE),
        .busy       (busy),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the current cycle's {T, READ, WRITE, instr_done}, then advance.
    task automatic cyc(input string tag, input logic [5:0] t_exp,
                       input logic rd, input logic wr, input logic done);
        chk(tag, {23'd0, T, READ, WRITE, instr_done}, {23'd0, t_exp, rd, wr, done});
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; halt_req = 1'b0;
        ir_op = 3'd0; ir_i = 1'b0; mem_ready = 1'b1;
        #12;
        chk("reset_outputs", {18'd0, T, D, READ, WRITE, busy, instr_done}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_after_reset", {26'd0, T}, 32'd0);

        // ir_op=2, ir_i=0
        start = 1'b1; ir_op = 3'd2; ir_i = 1'b0;
        tick();
        start = 1'b0;
        cyc("op2_T0", T0, 0, 0, 0);
        cyc("op2_T1", T1, 1, 0, 0);
        cyc("op2_T2", T2, 0, 0, 0);
        chk("op2_D", {24'd0, D}, 32'h04);
        cyc("op2_T3", T3, 0, 0, 0);
        cyc("op2_T4", T4, 1, 0, 0);
        cyc("op2_T5", T5, 0, 0, 1);

        // ir_op=3, ir_i=1
        ir_op = 3'd3; ir_i = 1'b1;
        cyc("op3_T0", T0, 0, 0, 0);
        cyc("op3_T1", T1, 1, 0, 0);
        cyc("op3_T2", T2, 0, 0, 0);
        chk("op3_D", {24'd0, D}, 32'h08);
        cyc("op3_T3", T3, 1, 0, 0);
        cyc("op3_T4", T4, 0, 1, 1);

        // ir_op=7, ir_i=1
        ir_op = 3'd7; ir_i = 1'b1;
        cyc("op7_T0", T0, 0, 0, 0);
        cyc("op7_T1", T1, 1, 0, 0);
        cyc("op7_T2", T2, 0, 0, 0);
        cyc("op7_T3", T3, 0, 0, 1);

        // ir_op=0 with halt pulsed at T1, start ignored while busy
        ir_op = 3'd0; ir_i = 1'b0;
        cyc("op0_T0", T0, 0, 0, 0);
        halt_req = 1'b1; start = 1'b1;
        cyc("op0_T1", T1, 1, 0, 0);
        halt_req = 1'b0; start = 1'b0;
        cyc("op0_T2", T2, 0, 0, 0);
        cyc("op0_T3", T3, 0, 0, 0);
        cyc("op0_T4", T4, 1, 0, 0);
        cyc("op0_T5", T5, 0, 0, 1);
        chk("halted_T", {26'd0, T}, 32'd0);
        chk("halted_busy_rw", {29'd0, busy, READ, WRITE}, 32'd0);
        chk("halted_D_kept", {24'd0, D}, 32'h01);
        tick();
        chk("halted_stays", {26'd0, T}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;

        // ir_op=6 with mem_ready low for two cycles at T5
        ir_op = 3'd6; ir_i = 1'b0;
        cyc("op6_T0", T0, 0, 0, 0);
        chk("op6_busy", {31'd0, busy}, 32'd1);
        cyc("op6_T1", T1, 1, 0, 0);
        cyc("op6_T2", T2, 0, 0, 0);
        cyc("op6_T3", T3, 0, 0, 0);
        cyc("op6_T4", T4, 1, 0, 0);
        mem_ready = 1'b0;
`ifdef MEM_ACCESS_SEQ_WAIT_EN
        cyc("op6_T5_nr1", T5, 0, 1, 0);
        cyc("op6_T5_nr2", T5, 0, 1, 0);
        mem_ready = 1'b1;
        cyc("op6_T5_rdy", T5, 0, 1, 1);
`else
        cyc("op6_T5", T5, 0, 1, 1);
        mem_ready = 1'b1;
`endif

        // ir_op=0, reset asserted while the T4 read is waiting
        ir_op = 3'd0; ir_i = 1'b0;
        cyc("rst_T0", T0, 0, 0, 0);
        cyc("rst_T1", T1, 1, 0, 0);
        cyc("rst_T2", T2, 0, 0, 0);
        cyc("rst_T3", T3, 0, 0, 0);
        mem_ready = 1'b0;
`ifdef MEM_ACCESS_SEQ_WAIT_EN
        cyc("rst_T4_nr", T4, 1, 0, 0);
        chk("rst_wait_busy", {31'd0, busy}, 32'd1);
`endif
        chk("rst_T4_read", {26'd0, T, READ, WRITE}, {26'd0, T4, 1'b1, 1'b0});
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {18'd0, T, D, READ, WRITE, busy, instr_done}, 32'd0);
        tick();
        rst = 1'b0; mem_ready = 1'b1;
        tick();
        tick();
        chk("rst_needs_start", {25'd0, T, busy}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc("restart_T0", T0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
